// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl_pkg.sv
// Shared definitions for the TPL DAC sync controller: FSM state encoding
// and the sync_mode trigger codes.
package ad_ip_jesd204_tpl_dac_sync_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DELAY = 2'd2
  } state_t;

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

endpackage

// File: rtl/ad_ip_jesd204_tpl_dac_sync_detect.sv
// Trigger detector: picks one external sync input, brings it into the clk
// domain through a SYNC_STAGES-deep synchroniser and turns it into a
// combinational trigger according to the selected edge/level mode.
module ad_ip_jesd204_tpl_dac_sync_detect
  import ad_ip_jesd204_tpl_dac_sync_ctrl_pkg::*;
#(
  parameter int NUM_SYNC_SOURCES = 1,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SYNC_SOURCES-1:0] ext_sync,
  input  logic [3:0]                  sync_src_sel,
  input  logic [1:0]                  sync_mode,
  output logic                        trig
);

  logic [15:0]            ext_pad;
  logic                   sync_sel;
  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_s;
  logic                   sync_s_d1;

  // Zero-pad the inputs to 16 so an out-of-range select reads constant 0.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave it unassigned and infer a latch.
    ext_pad                         = '0;
    ext_pad[NUM_SYNC_SOURCES-1:0]   = ext_sync;
  end

  assign sync_sel = ext_pad[sync_src_sel];
  assign sync_s   = sync_ff[SYNC_STAGES-1];

  // Synchroniser chain plus history flop; the history runs even when idle
  // so a fresh arm never sees an edge left over from long ago.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every register samples pre-edge values regardless of statement order.
    if (reset) begin
      sync_ff   <= '0;
      sync_s_d1 <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[SYNC_STAGES-2:0], sync_sel};
      sync_s_d1 <= sync_s;
    end
  end

  // Mode select: edge detectors compare the synchronised level to history.
  always_comb begin
    trig = 1'b0;
    case (sync_mode)
      MODE_RISE:  trig = sync_s & ~sync_s_d1;
      MODE_FALL:  trig = ~sync_s & sync_s_d1;
      MODE_BOTH:  trig = sync_s ^ sync_s_d1;
      MODE_LEVEL: trig = sync_s;
      default:    trig = 1'b0;
    endcase
  end

endmodule

// File: rtl/ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// TPL DAC sync controller: arms on a software request, waits for an
// external trigger (or a manual request), optionally delays, then emits a
// one-cycle sync pulse to the PN generators / DDS. DMA reads are held off
// while armed.
module ad_ip_jesd204_tpl_dac_sync_ctrl
  import ad_ip_jesd204_tpl_dac_sync_ctrl_pkg::*;
#(
  parameter int NUM_CHANNELS     = 1,
  parameter int NUM_SYNC_SOURCES = 1,
  parameter int SYNC_STAGES      = 2,
  parameter int DELAY_WIDTH      = 16,
  parameter int TIMEOUT_WIDTH    = 24
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        link_ready,
  input  logic [NUM_SYNC_SOURCES-1:0] ext_sync,
  input  logic [3:0]                  sync_src_sel,
  input  logic [1:0]                  sync_mode,
  input  logic                        arm_ctl,
  input  logic                        disarm,
  input  logic                        manual_sync,
  input  logic                        continuous,
  input  logic [DELAY_WIDTH-1:0]      sync_delay,
  input  logic [TIMEOUT_WIDTH-1:0]    timeout,
  output logic                        sync_pulse,
  output logic [NUM_CHANNELS-1:0]     dac_valid,
  output logic                        armed,
  output logic                        timeout_err,
  output logic [15:0]                 sync_count
);

  state_t                   state;
  logic [DELAY_WIDTH-1:0]   delay_cnt;
  logic [TIMEOUT_WIDTH-1:0] timeout_cnt;
  logic                     arm_ctl_d1;
  logic                     arm_rise;
  logic                     timeout_hit;
  logic                     trig;

  ad_ip_jesd204_tpl_dac_sync_detect #(
    .NUM_SYNC_SOURCES (NUM_SYNC_SOURCES),
    .SYNC_STAGES      (SYNC_STAGES)
  ) u_detect (
    .clk          (clk),
    .reset        (reset),
    .ext_sync     (ext_sync),
    .sync_src_sel (sync_src_sel),
    .sync_mode    (sync_mode),
    .trig         (trig)
  );

  assign arm_rise    = arm_ctl & ~arm_ctl_d1;
  assign timeout_hit = (timeout != '0) &&
                       (timeout_cnt == timeout - TIMEOUT_WIDTH'(1));
  assign dac_valid   = {NUM_CHANNELS{~armed & link_ready}};

  // Arm/trigger/delay FSM; priority is disarm > manual > arm > trig/timeout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      sync_pulse  <= 1'b0;
      armed       <= 1'b0;
      timeout_err <= 1'b0;
      sync_count  <= '0;
      delay_cnt   <= '0;
      timeout_cnt <= '0;
      arm_ctl_d1  <= 1'b0;
    end else begin
      arm_ctl_d1 <= arm_ctl;
      sync_pulse <= 1'b0;

      if (disarm) begin
        state <= ST_IDLE;
        armed <= 1'b0;
      end else if (manual_sync) begin
        sync_pulse <= 1'b1;
        sync_count <= sync_count + 16'd1;
        if (state != ST_IDLE && continuous) begin
          state       <= ST_ARMED;
          armed       <= 1'b1;
          timeout_cnt <= '0;
        end else begin
          state <= ST_IDLE;
          armed <= 1'b0;
        end
      end else begin
        case (state)
          ST_IDLE: begin
            if (arm_rise) begin
              state       <= ST_ARMED;
              armed       <= 1'b1;
              timeout_err <= 1'b0;
              timeout_cnt <= '0;
            end
          end

          ST_ARMED: begin
            if (arm_rise) begin
              timeout_cnt <= '0;
            end else if (trig) begin
              timeout_cnt <= '0;
              if (sync_delay == '0) begin
                sync_pulse <= 1'b1;
                sync_count <= sync_count + 16'd1;
                if (!continuous) begin
                  state <= ST_IDLE;
                  armed <= 1'b0;
                end
              end else begin
                delay_cnt <= sync_delay - DELAY_WIDTH'(1);
                state     <= ST_DELAY;
              end
            end else if (timeout_hit) begin
              timeout_err <= 1'b1;
              state       <= ST_IDLE;
              armed       <= 1'b0;
            end else if (timeout != '0) begin
              timeout_cnt <= timeout_cnt + TIMEOUT_WIDTH'(1);
            end
          end

          ST_DELAY: begin
            if (delay_cnt == '0) begin
              sync_pulse  <= 1'b1;
              sync_count  <= sync_count + 16'd1;
              timeout_cnt <= '0;
              if (continuous) begin
                state <= ST_ARMED;
              end else begin
                state <= ST_IDLE;
                armed <= 1'b0;
              end
            end else begin
              delay_cnt <= delay_cnt - DELAY_WIDTH'(1);
            end
          end

          default: begin
            state <= ST_IDLE;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_sync_ctrl.sv
// Directed bench for the TPL DAC sync controller. Expected sync_pulse edges
// are queued as stimulus is applied; a monitor pops and compares them.
module tb_ad_ip_jesd204_tpl_dac_sync_ctrl;

  localparam int NCH  = 4;
  localparam int NSRC = 2;
  localparam int DW   = 16;
  localparam int TW   = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic            link_ready;
  logic [NSRC-1:0] ext_sync;
  logic [3:0]      sync_src_sel;
  logic [1:0]      sync_mode;
  logic            arm_ctl;
  logic            disarm;
  logic            manual_sync;
  logic            continuous;
  logic [DW-1:0]   sync_delay;
  logic [TW-1:0]   timeout;
  logic            sync_pulse;
  logic [NCH-1:0]  dac_valid;
  logic            armed;
  logic            timeout_err;
  logic [15:0]     sync_count;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int mon_e;
  bit mon_en = 1'b1;
  int exp_q[$];

  ad_ip_jesd204_tpl_dac_sync_ctrl #(
    .NUM_CHANNELS     (NCH),
    .NUM_SYNC_SOURCES (NSRC),
    .SYNC_STAGES      (2),
    .DELAY_WIDTH      (DW),
    .TIMEOUT_WIDTH    (TW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .link_ready   (link_ready),
    .ext_sync     (ext_sync),
    .sync_src_sel (sync_src_sel),
    .sync_mode    (sync_mode),
    .arm_ctl      (arm_ctl),
    .disarm       (disarm),
    .manual_sync  (manual_sync),
    .continuous   (continuous),
    .sync_delay   (sync_delay),
    .timeout      (timeout),
    .sync_pulse   (sync_pulse),
    .dac_valid    (dac_valid),
    .armed        (armed),
    .timeout_err  (timeout_err),
    .sync_count   (sync_count)
  );

  always #5 clk = ~clk;

  // Edge counter: at the negedge after posedge k, cyc == k.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor: every pulse must match the oldest queued edge.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sync_pulse === 1'b1) begin
        mon_e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check("pulse_edge", cyc, mon_e);
      end
      if (exp_q.size() > 0 && exp_q[0] < cyc) begin
        mon_e = exp_q.pop_front();
        check("pulse_missed", cyc, mon_e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm(input string tag);
    arm_ctl = 1'b1;
    tick(1);
    arm_ctl = 1'b0;
    check(tag, armed, 1'b1);
  endtask

  initial begin
    reset        = 1'b1;
    link_ready   = 1'b1;
    ext_sync     = '0;
    sync_src_sel = 4'd0;
    sync_mode    = 2'b00;
    arm_ctl      = 1'b0;
    disarm       = 1'b0;
    manual_sync  = 1'b0;
    continuous   = 1'b0;
    sync_delay   = '0;
    timeout      = '0;
    tick(3);
    check("rst_pulse", sync_pulse, 1'b0);
    check("rst_armed", armed, 1'b0);
    check("rst_terr", timeout_err, 1'b0);
    check("rst_count", sync_count, 16'd0);
    reset = 1'b0;
    tick(2);
    check("rst_valid", dac_valid, 4'hF);

    // 1: rising, source 0, no delay
    do_arm("t1_arm");
    check("t1_valid_armed", dac_valid, 4'h0);
    ext_sync[0] = 1'b1;
    exp_q.push_back(cyc + 3);
    tick(4);
    check("t1_armed", armed, 1'b0);
    check("t1_count", sync_count, 16'd1);
    check("t1_valid", dac_valid, 4'hF);
    ext_sync[0] = 1'b0;
    tick(3);

    // 2: falling, source 1, delay 5, extra edge during DELAY ignored
    sync_mode    = 2'b01;
    sync_src_sel = 4'd1;
    sync_delay   = 16'd5;
    ext_sync[1]  = 1'b1;
    tick(4);
    do_arm("t2_arm");
    ext_sync[1] = 1'b0;
    exp_q.push_back(cyc + 8);
    tick(2);
    ext_sync[1] = 1'b1;
    tick(1);
    check("t2_armed_in_delay", armed, 1'b1);
    ext_sync[1] = 1'b0;
    tick(7);
    check("t2_count", sync_count, 16'd2);
    check("t2_armed", armed, 1'b0);
    check("t2_sb_empty", exp_q.size(), 0);

    // 3: timeout 10 with no trigger, re-arm clears error, then timeout 1
    sync_mode    = 2'b00;
    sync_src_sel = 4'd0;
    sync_delay   = '0;
    timeout      = 24'd10;
    do_arm("t3_arm");
    tick(9);
    check("t3_armed_pre", armed, 1'b1);
    check("t3_terr_pre", timeout_err, 1'b0);
    tick(1);
    check("t3_armed_post", armed, 1'b0);
    check("t3_terr_post", timeout_err, 1'b1);
    do_arm("t3_rearm");
    check("t3_terr_clr", timeout_err, 1'b0);
    disarm = 1'b1;
    tick(1);
    disarm  = 1'b0;
    timeout = 24'd1;
    tick(2);
    do_arm("t3_arm1");
    tick(1);
    check("t3_to1_armed", armed, 1'b0);
    check("t3_to1_terr", timeout_err, 1'b1);
    timeout = '0;
    check("t3_count", sync_count, 16'd2);

    // 4: continuous, both edges, three toggles
    continuous = 1'b1;
    sync_mode  = 2'b10;
    tick(2);
    do_arm("t4_arm");
    for (int i = 0; i < 3; i++) begin
      ext_sync[0] = ~ext_sync[0];
      exp_q.push_back(cyc + 3);
      tick(4);
      check("t4_armed", armed, 1'b1);
      check("t4_valid", dac_valid, 4'h0);
    end
    check("t4_count", sync_count, 16'd5);
    disarm = 1'b1;
    tick(1);
    disarm     = 1'b0;
    continuous = 1'b0;
    check("t4_disarmed", armed, 1'b0);

    // 5: disarm coincident with trigger, then manual sync in IDLE
    sync_mode   = 2'b00;
    ext_sync[0] = 1'b0;
    tick(4);
    do_arm("t5_arm");
    ext_sync[0] = 1'b1;
    tick(2);
    disarm = 1'b1;
    tick(1);
    disarm = 1'b0;
    check("t5_armed", armed, 1'b0);
    tick(4);
    check("t5_count_nopulse", sync_count, 16'd5);
    manual_sync = 1'b1;
    exp_q.push_back(cyc + 1);
    tick(1);
    manual_sync = 1'b0;
    tick(2);
    check("t5_count_manual", sync_count, 16'd6);

    // Manual sync during DELAY aborts the delayed pulse
    ext_sync[0] = 1'b0;
    sync_delay  = 16'd5;
    tick(4);
    do_arm("t5b_arm");
    ext_sync[0] = 1'b1;
    tick(4);
    check("t5b_in_delay", armed, 1'b1);
    manual_sync = 1'b1;
    exp_q.push_back(cyc + 1);
    tick(1);
    manual_sync = 1'b0;
    tick(8);
    check("t5b_count", sync_count, 16'd7);
    check("t5b_armed", armed, 1'b0);

    // 6: reset in DELAY drops the pulse, then counter wrap
    ext_sync[0] = 1'b0;
    tick(4);
    do_arm("t6_arm");
    ext_sync[0] = 1'b1;
    tick(4);
    reset = 1'b1;
    tick(1);
    check("t6_rst_armed", armed, 1'b0);
    check("t6_rst_count", sync_count, 16'd0);
    check("t6_rst_valid", dac_valid, 4'hF);
    reset = 1'b0;
    tick(8);
    check("t6_no_pulse", sync_count, 16'd0);

    mon_en      = 1'b0;
    manual_sync = 1'b1;
    tick(65535);
    check("t6_count_ffff", sync_count, 16'hFFFF);
    tick(1);
    check("t6_count_wrap", sync_count, 16'h0000);
    manual_sync = 1'b0;
    tick(3);
    mon_en = 1'b1;
    tick(2);
    check("final_sb_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
